// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared widths and types for the two-master cache-port arbiter.
// Revision    : 1.0
// ============================================================================
package cache_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int PROT_W = 3;
  localparam int RESP_W = 2;

  // ARB_RESP doubles as the DATA phase of the read group.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef logic port_t;

  function automatic port_t fixed_pick(input logic [1:0] req);
    return req[0] ? 1'b0 : 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_if
// Description : AXI4-Lite channel bundle with master/slave modports.
// Revision    : 1.0
// ============================================================================
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [PROT_W-1:0] awprot;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  logic [RESP_W-1:0] bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [PROT_W-1:0] arprot;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/cache_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_grant
// Description : Two-request grant decision, fixed priority or round-robin.
//               Round-robin selected by CACHE_ARBITER_ROUND_ROBIN_EN.
// Revision    : 1.0
// ============================================================================
module cache_arbiter_grant
  import cache_arbiter_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       load,
  output port_t      grant
);

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  port_t r_last;

  // Pointer starts at "last = 1" so the first contested grant goes to port 0.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last <= 1'b1;
    end else if (load) begin
      r_last <= grant;
    end
  end

  always_comb begin
    grant = fixed_pick(req);
    if (&req) begin
      grant = ~r_last;
    end
  end
`else
  logic w_unused;

  assign grant    = fixed_pick(req);
  assign w_unused = &{1'b0, aclk, aresetn, load};
`endif

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Two-master to one-slave AXI4-Lite arbiter, independent read
//               and write groups, one outstanding transaction per group.
//               Policy macro: CACHE_ARBITER_ROUND_ROBIN_EN (round-robin).
// Revision    : 1.0
// ============================================================================
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic                  aclk,
  input  logic                  aresetn,
  cache_arbiter_if.slave        s0,
  cache_arbiter_if.slave        s1,
  cache_arbiter_if.master       m,
  output port_t                 rgrant,
  output logic                  rbusy,
  output port_t                 wgrant,
  output logic                  wbusy
);

  // --------------------------------------------------------------------------
  // Read group
  // --------------------------------------------------------------------------
  arb_state_t r_rstate;
  arb_state_t w_rstate_nxt;
  port_t      r_rgrant;
  port_t      w_rgrant_arb;
  logic [1:0] w_rreq;
  logic       w_rload;
  logic       w_rd_addr;
  logic       w_rd_data;
  logic       w_m_arvalid;
  logic       w_m_rready;
  logic       w_ar_hs;
  logic       w_r_hs;

  assign w_rreq    = {s1.arvalid, s0.arvalid};
  assign w_rload   = (r_rstate == ARB_IDLE) && (|w_rreq);
  assign w_rd_addr = (r_rstate == ARB_ADDR);
  assign w_rd_data = (r_rstate == ARB_RESP);

  cache_arbiter_grant u_rgrant (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (w_rreq),
    .load    (w_rload),
    .grant   (w_rgrant_arb)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate <= ARB_IDLE;
      r_rgrant <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_rload) begin
        r_rgrant <= w_rgrant_arb;
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      ARB_IDLE: if (|w_rreq) w_rstate_nxt = ARB_ADDR;
      ARB_ADDR: if (w_ar_hs) w_rstate_nxt = ARB_RESP;
      ARB_RESP: if (w_r_hs)  w_rstate_nxt = ARB_IDLE;
      default:               w_rstate_nxt = ARB_IDLE;
    endcase
  end

  assign w_m_arvalid = w_rd_addr & (r_rgrant ? s1.arvalid : s0.arvalid);
  assign w_m_rready  = w_rd_data & (r_rgrant ? s1.rready  : s0.rready);
  assign w_ar_hs     = w_m_arvalid & m.arready;
  assign w_r_hs      = m.rvalid & w_m_rready;

  assign m.araddr  = r_rgrant ? s1.araddr : s0.araddr;
  assign m.arprot  = r_rgrant ? s1.arprot : s0.arprot;
  assign m.arvalid = w_m_arvalid;
  assign m.rready  = w_m_rready;

  assign s0.arready = w_rd_addr & ~r_rgrant & m.arready;
  assign s1.arready = w_rd_addr &  r_rgrant & m.arready;
  assign s0.rvalid  = w_rd_data & ~r_rgrant & m.rvalid;
  assign s1.rvalid  = w_rd_data &  r_rgrant & m.rvalid;
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;

  assign rgrant = r_rgrant;
  assign rbusy  = (r_rstate != ARB_IDLE);

  // --------------------------------------------------------------------------
  // Write group
  // --------------------------------------------------------------------------
  arb_state_t r_wstate;
  arb_state_t w_wstate_nxt;
  port_t      r_wgrant;
  port_t      w_wgrant_arb;
  logic [1:0] w_wreq;
  logic       w_wload;
  logic       w_wr_addr;
  logic       w_wr_resp;
  logic       r_aw_done;
  logic       r_w_done;
  logic       w_m_awvalid;
  logic       w_m_wvalid;
  logic       w_m_bready;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_addr_phase_done;
  logic       w_b_hs;

  assign w_wreq    = {s1.awvalid, s0.awvalid};
  assign w_wload   = (r_wstate == ARB_IDLE) && (|w_wreq);
  assign w_wr_addr = (r_wstate == ARB_ADDR);
  assign w_wr_resp = (r_wstate == ARB_RESP);

  cache_arbiter_grant u_wgrant (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (w_wreq),
    .load    (w_wload),
    .grant   (w_wgrant_arb)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate <= ARB_IDLE;
      r_wgrant <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_wload) begin
        r_wgrant <= w_wgrant_arb;
      end
    end
  end

  // AW and W may complete in either order or together; each is masked once done.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_wr_addr) begin
      if (w_addr_phase_done) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      ARB_IDLE: if (|w_wreq)           w_wstate_nxt = ARB_ADDR;
      ARB_ADDR: if (w_addr_phase_done) w_wstate_nxt = ARB_RESP;
      ARB_RESP: if (w_b_hs)            w_wstate_nxt = ARB_IDLE;
      default:                         w_wstate_nxt = ARB_IDLE;
    endcase
  end

  assign w_m_awvalid = w_wr_addr & ~r_aw_done & (r_wgrant ? s1.awvalid : s0.awvalid);
  assign w_m_wvalid  = w_wr_addr & ~r_w_done  & (r_wgrant ? s1.wvalid  : s0.wvalid);
  assign w_m_bready  = w_wr_resp & (r_wgrant ? s1.bready : s0.bready);
  assign w_aw_hs     = w_m_awvalid & m.awready;
  assign w_w_hs      = w_m_wvalid  & m.wready;
  assign w_b_hs      = m.bvalid & w_m_bready;
  assign w_addr_phase_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  assign m.awaddr  = r_wgrant ? s1.awaddr : s0.awaddr;
  assign m.awprot  = r_wgrant ? s1.awprot : s0.awprot;
  assign m.awvalid = w_m_awvalid;
  assign m.wdata   = r_wgrant ? s1.wdata  : s0.wdata;
  assign m.wstrb   = r_wgrant ? s1.wstrb  : s0.wstrb;
  assign m.wvalid  = w_m_wvalid;
  assign m.bready  = w_m_bready;

  assign s0.awready = w_wr_addr & ~r_aw_done & ~r_wgrant & m.awready;
  assign s1.awready = w_wr_addr & ~r_aw_done &  r_wgrant & m.awready;
  assign s0.wready  = w_wr_addr & ~r_w_done  & ~r_wgrant & m.wready;
  assign s1.wready  = w_wr_addr & ~r_w_done  &  r_wgrant & m.wready;
  assign s0.bvalid  = w_wr_resp & ~r_wgrant & m.bvalid;
  assign s1.bvalid  = w_wr_resp &  r_wgrant & m.bvalid;
  assign s0.bresp   = m.bresp;
  assign s1.bresp   = m.bresp;

  assign wgrant = r_wgrant;
  assign wbusy  = (r_wstate != ARB_IDLE);

endmodule
`default_nettype wire
